ycbcr2rgb_pipe: RTL

Parametrised, fully pipelined YCbCr to RGB colour-space converter for the video path. It sits after the decoder or scaler and before the RGB display and output stage. Selectable conversion standard and range: BT.601 limited, BT.709 limited, BT.601 full, and bypass. Video sync/enable sideband is delayed to stay aligned with pixels. A clock enable stalls the whole pipeline.

---
 rtl/ycc_pkg.sv | 39 +++
 rtl/ycbcr2rgb_pipe_if.sv | 28 ++
 rtl/ycc_round_clamp.sv | 25 ++
 rtl/ycbcr2rgb_pipe.sv | 128 ++++++++++++
 4 files changed

// File: rtl/ycc_pkg.sv
// YCbCr to RGB converter shared types.
// Modes, Q2.10 coefficient table and offset helpers.
package ycc_pkg;

    typedef enum logic [1:0] {
        MODE_601L = 2'b00,
        MODE_709L = 2'b01,
        MODE_601F = 2'b10,
        MODE_BYP  = 2'b11
    } mode_e;

    localparam int LAT = 4;
    localparam int KW  = 12;

    typedef struct packed {
        logic [KW-1:0] ky;
        logic [KW-1:0] kr;
        logic [KW-1:0] kgr;
        logic [KW-1:0] kgb;
        logic [KW-1:0] kb;
    } coef_t;

    // Packed so entry [0] is MODE_601L; bypass row is never multiplied in.
    localparam coef_t [3:0] COEF_TAB = {
        {12'd0,    12'd0,    12'd0,   12'd0,   12'd0},
        {12'd1024, 12'd1436, 12'd731, 12'd352, 12'd1815},
        {12'd1192, 12'd1836, 12'd546, 12'd218, 12'd2163},
        {12'd1192, 12'd1634, 12'd833, 12'd401, 12'd2066}
    };

    function automatic int y_off(int dw);
        return 16 << (dw - 8);
    endfunction

    function automatic int c_off(int dw);
        return 128 << (dw - 8);
    endfunction

endpackage

// File: rtl/ycbcr2rgb_pipe_if.sv
// Pixel bus into and out of the colour converter.
// Sync/enable sideband travels with the three components.
interface ycbcr2rgb_pipe_if #(
    parameter int DW = 8
);
    logic          in_vs;
    logic          in_hs;
    logic          in_de;
    logic [DW-1:0] in_y;
    logic [DW-1:0] in_cb;
    logic [DW-1:0] in_cr;
    logic          out_vs;
    logic          out_hs;
    logic          out_de;
    logic [DW-1:0] out_r;
    logic [DW-1:0] out_g;
    logic [DW-1:0] out_b;

    modport master (
        output in_vs, in_hs, in_de, in_y, in_cb, in_cr,
        input  out_vs, out_hs, out_de, out_r, out_g, out_b
    );

    modport slave (
        input  in_vs, in_hs, in_de, in_y, in_cb, in_cr,
        output out_vs, out_hs, out_de, out_r, out_g, out_b
    );
endinterface

// File: rtl/ycc_round_clamp.sv
// Round-half-up a signed fixed-point sum and saturate
// it to an unsigned DW-bit component.
module ycc_round_clamp #(
    parameter int DW = 8,
    parameter int CF = 10,
    parameter int SW = 23
) (
    input  logic signed [SW-1:0] s,
    output logic        [DW-1:0] q
);
    localparam logic signed [SW-1:0] HALF = SW'(1 << (CF - 1));
    localparam logic signed [SW-1:0] MAXV = SW'((1 << DW) - 1);

    logic signed [SW-1:0] t;

    assign t = (s + HALF) >>> CF;

    always_comb begin
        q = t[DW-1:0];
        if (t < 0)
            q = '0;
        else if (t > MAXV)
            q = '1;
    end
endmodule

// File: rtl/ycbcr2rgb_pipe.sv
// Four-stage YCbCr to RGB converter with per-stage mode
// tracking, sideband delay and global clock enable.
module ycbcr2rgb_pipe #(
    parameter int DW  = 8,
    parameter int CF  = 10,
    parameter int LAT = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            ce,
    input  logic [1:0]      mode,
    ycbcr2rgb_pipe_if.slave bus,
    output logic [1:0]      mode_q
);
    import ycc_pkg::*;

    localparam int PW = DW + 13;
    localparam int SW = DW + 15;
    localparam logic signed [DW:0] YOFF = (DW+1)'(y_off(DW));
    localparam logic signed [DW:0] COFF = (DW+1)'(c_off(DW));

    mode_e                mode_r, m_in, m1, m2, m3;
    logic                 vs_prev, vs_rise;
    logic signed [DW:0]   yoff_c, yo_c, cb_c, cr_c;
    logic signed [DW:0]   yo1, cb1, cr1;
    logic [3*DW-1:0]      raw1, raw2, raw3;
    logic signed [PW-1:0] py, pr, pgr, pgb, pb;
    logic signed [SW-1:0] s_r, s_g, s_b;
    logic [DW-1:0]        rc_r, rc_g, rc_b;
    logic [DW-1:0]        r_q, g_q, b_q;
    logic [2:0]           side_q [LAT];
    coef_t                k;

    // The pixel arriving with the vs edge already uses the new mode.
    assign vs_rise = bus.in_vs & ~vs_prev;
    assign m_in    = vs_rise ? mode_e'(mode) : mode_r;
    assign k       = COEF_TAB[m1];
    assign mode_q  = mode_r;

    always_comb begin
        yoff_c = (m_in == MODE_601F) ? '0 : YOFF;
        yo_c   = $signed({1'b0, bus.in_y}) - yoff_c;
        cb_c   = $signed({1'b0, bus.in_cb}) - COFF;
        cr_c   = $signed({1'b0, bus.in_cr}) - COFF;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vs_prev <= 1'b0;
            mode_r  <= MODE_601L;
            m1      <= MODE_601L;
            m2      <= MODE_601L;
            m3      <= MODE_601L;
            yo1     <= '0;
            cb1     <= '0;
            cr1     <= '0;
            raw1    <= '0;
            raw2    <= '0;
            raw3    <= '0;
            py      <= '0;
            pr      <= '0;
            pgr     <= '0;
            pgb     <= '0;
            pb      <= '0;
            s_r     <= '0;
            s_g     <= '0;
            s_b     <= '0;
            r_q     <= '0;
            g_q     <= '0;
            b_q     <= '0;
            for (int i = 0; i < LAT; i++)
                side_q[i] <= '0;
        end else if (ce) begin
            vs_prev <= bus.in_vs;
            if (vs_rise)
                mode_r <= mode_e'(mode);
            m1   <= m_in;
            yo1  <= yo_c;
            cb1  <= cb_c;
            cr1  <= cr_c;
            raw1 <= {bus.in_cr, bus.in_y, bus.in_cb};
            m2   <= m1;
            raw2 <= raw1;
            py   <= PW'(yo1) * PW'($signed({1'b0, k.ky}));
            pr   <= PW'(cr1) * PW'($signed({1'b0, k.kr}));
            pgr  <= PW'(cr1) * PW'($signed({1'b0, k.kgr}));
            pgb  <= PW'(cb1) * PW'($signed({1'b0, k.kgb}));
            pb   <= PW'(cb1) * PW'($signed({1'b0, k.kb}));
            m3   <= m2;
            raw3 <= raw2;
            s_r  <= SW'(py) + SW'(pr);
            s_g  <= SW'(py) - SW'(pgr) - SW'(pgb);
            s_b  <= SW'(py) + SW'(pb);
            if (m3 == MODE_BYP) begin
                {r_q, g_q, b_q} <= raw3;
            end else begin
                r_q <= rc_r;
                g_q <= rc_g;
                b_q <= rc_b;
            end
            side_q[0] <= {bus.in_vs, bus.in_hs, bus.in_de};
            for (int i = 1; i < LAT; i++)
                side_q[i] <= side_q[i-1];
        end
    end

    ycc_round_clamp #(.DW(DW), .CF(CF), .SW(SW)) u_rc_r (
        .s (s_r),
        .q (rc_r)
    );

    ycc_round_clamp #(.DW(DW), .CF(CF), .SW(SW)) u_rc_g (
        .s (s_g),
        .q (rc_g)
    );

    ycc_round_clamp #(.DW(DW), .CF(CF), .SW(SW)) u_rc_b (
        .s (s_b),
        .q (rc_b)
    );

    assign bus.out_r  = r_q;
    assign bus.out_g  = g_q;
    assign bus.out_b  = b_q;
    assign bus.out_vs = side_q[LAT-1][2];
    assign bus.out_hs = side_q[LAT-1][1];
    assign bus.out_de = side_q[LAT-1][0];
endmodule
